// File: rtl/i2c_master.sv
// i2c_master: single-master I2C controller issuing register-addressed write and
// read transactions (START, address, sub-address, data bytes, STOP).
// Optional: define I2C_NACK_ABORT_EN to end a transaction with STOP as soon as
// a slave NACKs any master-transmitted byte.
module i2c_master #(
  parameter int QTR_DIV = 125
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       WR,
  input  logic [7:0] length,
  input  logic       request,
  input  logic [6:0] address,
  input  logic [7:0] sub_address,
  input  logic [7:0] txReg,
  output logic [7:0] rxReg,
  output logic       DE,
  inout  wire        SDA,
  output logic       SCL,
  output logic       busy,
  output logic [3:0] scl_ticks
);
  localparam int QW = $clog2(QTR_DIV);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, SUB, RSTART, ADDR_R, WDATA, RDATA, STOP
  } state_t;

  // transaction fields captured when the transaction starts
  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] sub;
  } txn_t;

  state_t        state, state_nxt;
  txn_t          txn;
  logic [QW-1:0] qcnt;
  logic          qtick;
  logic [1:0]    q;
  logic [3:0]    bit_idx;
  logic [7:0]    shifter, cnt;
  logic          sda_oe, abort;
  logic [1:0]    sda_sync;
  logic          byte_st, tx_st, frame_end;

  assign SDA       = sda_oe ? 1'b0 : 1'bz;
  assign scl_ticks = bit_idx;

  assign qtick     = (state != IDLE) && (qcnt == QW'(QTR_DIV - 1));
  assign byte_st   = state inside {ADDR_W, SUB, ADDR_R, WDATA, RDATA};
  assign tx_st     = byte_st && (state != RDATA);
  assign frame_end = byte_st && qtick && (q == 2'd3) && (bit_idx == 4'd8);

`ifdef I2C_NACK_ABORT_EN
  logic nack;
  assign abort = tx_st && nack;
`else
  assign abort = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: phase states advance on quarter count, byte states on frame end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (request) state_nxt = START;
      START:   if (qtick && q == 2'd1) state_nxt = ADDR_W;
      ADDR_W:  if (frame_end) state_nxt = abort ? STOP : SUB;
      SUB:     if (frame_end) state_nxt = abort ? STOP : (txn.wr ? WDATA : RSTART);
      RSTART:  if (qtick && q == 2'd2) state_nxt = ADDR_R;
      ADDR_R:  if (frame_end) state_nxt = abort ? STOP : RDATA;
      WDATA:   if (frame_end) state_nxt = (abort || cnt == 8'd1) ? STOP : WDATA;
      RDATA:   if (frame_end) state_nxt = (cnt == 8'd1) ? STOP : RDATA;
      STOP:    if (qtick && q == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // quarter-period timer; held at zero while idle so START gets a full quarter
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)                       qcnt <= '0;
    else if (state == IDLE || qtick)  qcnt <= '0;
    else                              qcnt <= qcnt + 1'b1;
  end

  // two-flop synchronizer on the bus data line
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], SDA};
  end

  // bus sequencing: SDA moves at the start of quarter 1, sampled at end of quarter 2
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      SCL     <= 1'b1;
      sda_oe  <= 1'b0;
      DE      <= 1'b0;
      busy    <= 1'b0;
      rxReg   <= '0;
      q       <= '0;
      bit_idx <= '0;
      shifter <= '0;
      cnt     <= '0;
      txn     <= '0;
`ifdef I2C_NACK_ABORT_EN
      nack    <= 1'b0;
`endif
    end else begin
      DE <= 1'b0;
      if (state_nxt != state) q <= 2'd0;
      else if (qtick)         q <= q + 2'd1;

      if (state == IDLE && request) begin
        busy     <= 1'b1;
        txn.wr   <= WR;
        txn.addr <= address;
        txn.sub  <= sub_address;
        cnt      <= (length == 8'd0) ? 8'd1 : length;
      end

      if (qtick) begin
        case (state)
          START: begin
            if (q == 2'd0) sda_oe <= 1'b1;
            if (q == 2'd1) begin
              SCL     <= 1'b0;
              shifter <= {txn.addr, 1'b0};
            end
          end
          RSTART: begin
            if (q == 2'd0) SCL    <= 1'b1;
            if (q == 2'd1) sda_oe <= 1'b1;
            if (q == 2'd2) begin
              SCL     <= 1'b0;
              shifter <= {txn.addr, 1'b1};
            end
          end
          STOP: begin
            case (q)
              2'd0: sda_oe <= 1'b1;
              2'd1: SCL    <= 1'b1;
              2'd2: sda_oe <= 1'b0;
              2'd3: busy   <= 1'b0;
            endcase
          end
          IDLE: ;
          default: begin
            case (q)
              // data bit: drive MSB when transmitting; ACK slot: release, or ACK a read with more to come
              2'd0: if (bit_idx != 4'd8) sda_oe <= tx_st & ~shifter[7];
                    else                 sda_oe <= (state == RDATA) && (cnt != 8'd1);
              2'd1: SCL <= 1'b1;
              2'd2: begin
                if (bit_idx != 4'd8) begin
                  shifter <= {shifter[6:0], sda_sync[1]};
                  if (state == RDATA && bit_idx == 4'd7) begin
                    rxReg <= {shifter[6:0], sda_sync[1]};
                    DE    <= 1'b1;
                  end
                end
`ifdef I2C_NACK_ABORT_EN
                else nack <= sda_sync[1];
`endif
              end
              2'd3: begin
                SCL <= 1'b0;
                if (bit_idx != 4'd8) bit_idx <= bit_idx + 4'd1;
                else begin
                  bit_idx <= '0;
                  if (state == WDATA || state == RDATA) cnt <= cnt - 8'd1;
                  if (state_nxt == SUB) shifter <= txn.sub;
                  // next write byte is taken here; DE tells the host to queue another
                  if (state_nxt == WDATA) begin
                    shifter <= txReg;
                    DE      <= 1'b1;
                  end
                end
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench. Stimulus pushes expected bus/host events
// (START, byte+ACK, DE, STOP) into a queue; a bus monitor that also plays the
// slave pops and compares each event as it appears.
module tb_i2c_master;
  localparam int QTR_DIV = 4;
  localparam int K_S = 1, K_P = 2, K_B = 3, K_DW = 4, K_DR = 5;

  logic       clk_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       WR = 1'b0;
  logic [7:0] length = '0;
  logic       request = 1'b0;
  logic [6:0] address = '0;
  logic [7:0] sub_address = '0;
  logic [7:0] txReg = '0;
  logic [7:0] rxReg;
  logic       DE, SCL, busy;
  logic [3:0] scl_ticks;
  wire        SDA;
  logic       slv_oe = 1'b0;

  assign SDA = slv_oe ? 1'b0 : 1'bz;
  pullup (SDA);

  i2c_master #(.QTR_DIV(QTR_DIV)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .WR(WR), .length(length), .request(request),
    .address(address), .sub_address(sub_address), .txReg(txReg), .rxReg(rxReg),
    .DE(DE), .SDA(SDA), .SCL(SCL), .busy(busy), .scl_ticks(scl_ticks)
  );

  always #5 clk_50 = ~clk_50;

  int         tests = 0, fails = 0;
  int         exp_q[$];
  logic [7:0] rd_q[$];
  logic       mon_en = 1'b0;
  logic       nack_addr = 1'b0;

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int btok(logic [7:0] b, logic a);
    return K_B * 1024 + int'({b, a});
  endfunction

  task automatic push(int tok);
    exp_q.push_back(tok);
  endtask

  task automatic observe(int tok);
    int e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: got 0x%0h, expected none", tok);
    end else begin
      e = exp_q.pop_front();
      check("bus_event", tok, e);
    end
  endtask

  // bus monitor + slave model, polled away from the active edge
  initial begin : monitor
    logic       scl_p, sda_p, rd_mode;
    logic [8:0] sh;
    logic [7:0] txb;
    int         bitn, byten;
    scl_p = 1'b1; sda_p = 1'b1; rd_mode = 1'b0; sh = '0; txb = '0; bitn = 0; byten = 0;
    forever begin
      @(negedge clk_50);
      if (!mon_en) begin
        bitn = 0; byten = 0; rd_mode = 1'b0; slv_oe = 1'b0;
      end else begin
        if (DE) observe(rd_mode ? (K_DR * 1024 + int'(rxReg)) : K_DW * 1024);
        if (SCL && scl_p && !SDA && sda_p) begin
          observe(K_S * 1024);
          check("busy_at_start", int'(busy), 1);
          bitn = 0; byten = 0; rd_mode = 1'b0;
        end else if (SCL && scl_p && SDA && !sda_p) begin
          observe(K_P * 1024);
          check("busy_at_stop", int'(busy), 1);
          bitn = 0; byten = 0; rd_mode = 1'b0;
        end else if (SCL && !scl_p) begin
          check("scl_ticks", int'(scl_ticks), bitn);
          sh = {sh[7:0], SDA};
          bitn++;
          if (bitn == 9) begin
            observe(K_B * 1024 + int'(sh));
            if (byten == 0)            rd_mode = sh[1];
            else if (rd_mode && sh[0]) rd_mode = 1'b0;
            byten++;
            bitn = 0;
          end
        end else if (!SCL && scl_p) begin
          if (bitn == 8) slv_oe = !rd_mode && !(nack_addr && byten == 0);
          else if (rd_mode && byten > 0) begin
            if (bitn == 0) txb = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hFF;
            slv_oe = !txb[7 - bitn];
          end else slv_oe = 1'b0;
        end
      end
      scl_p = SCL;
      sda_p = SDA;
    end
  end

  task automatic wait_busy(logic lvl, string name);
    int n = 0;
    while (busy !== lvl && n < 20000) begin
      @(negedge clk_50);
      n++;
    end
    if (busy !== lvl) begin
      tests++; fails++;
      $display("FAIL %s: busy timed out at %b, expected %b", name, busy, lvl);
    end
  endtask

  // start one transaction, then scramble the sampled inputs to prove they were latched
  task automatic start_txn(logic wr, logic [7:0] len, logic [6:0] a, logic [7:0] s, logic [7:0] d);
    WR = wr; length = len; address = a; sub_address = s; txReg = d;
    request = 1'b1;
    wait_busy(1'b1, "busy_rise");
    request = 1'b0;
    WR = ~wr; length = 8'd5; address = 7'h11; sub_address = 8'hEE;
  endtask

  task automatic finish_txn(string name);
    wait_busy(1'b0, name);
    repeat (4 * QTR_DIV) @(negedge clk_50);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_busy_idle"}, int'(busy), 0);
  endtask

  task automatic push_write(logic [7:0] s, logic [7:0] d);
    push(K_S * 1024); push(btok(8'h98, 1'b0)); push(btok(s, 1'b0));
    push(K_DW * 1024); push(btok(d, 1'b0)); push(K_P * 1024);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] stream;
    int          n;
    repeat (5) @(negedge clk_50);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50);
    check("rst_scl", int'(SCL), 1);
    check("rst_sda", int'(SDA), 1);
    check("rst_de", int'(DE), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rxreg", int'(rxReg), 0);
    check("rst_ticks", int'(scl_ticks), 0);
    mon_en = 1'b1;

    // single-byte write
    push_write(8'h01, 8'h12);
    start_txn(1'b1, 8'd1, 7'h4C, 8'h01, 8'h12);
    finish_txn("wr1");

    // held request: four back-to-back writes, txReg reloaded on each DE
    stream = 32'h78563412;
    for (int k = 0; k < 4; k++) push_write(8'h01, stream[8*k +: 8]);
    WR = 1'b1; length = 8'd1; address = 7'h4C; sub_address = 8'h01; txReg = stream[7:0];
    request = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk_50);
        n++;
      end while (!DE && n < 20000);
      if (!DE) begin
        tests++; fails++;
        $display("FAIL stream_de: DE never pulsed, expected pulse %0d", k);
      end
      if (k < 3) txReg = stream[8*(k+1) +: 8];
      else       request = 1'b0;
    end
    finish_txn("stream");

    // two-byte read with repeated START
    rd_q.push_back(8'hA5); rd_q.push_back(8'h3C);
    push(K_S * 1024); push(btok(8'h98, 1'b0)); push(btok(8'h05, 1'b0));
    push(K_S * 1024); push(btok(8'h99, 1'b0));
    push(K_DR * 1024 + 'hA5); push(btok(8'hA5, 1'b0));
    push(K_DR * 1024 + 'h3C); push(btok(8'h3C, 1'b1));
    push(K_P * 1024);
    start_txn(1'b0, 8'd2, 7'h4C, 8'h05, 8'h00);
    finish_txn("rd2");
    check("rd2_rxreg", int'(rxReg), 'h3C);

    // length 0 behaves as length 1
    push_write(8'h02, 8'h5A);
    start_txn(1'b1, 8'd0, 7'h4C, 8'h02, 8'h5A);
    finish_txn("len0");

    // slave NACKs the address byte
    nack_addr = 1'b1;
`ifdef I2C_NACK_ABORT_EN
    push(K_S * 1024); push(btok(8'h98, 1'b1)); push(K_P * 1024);
`else
    push(K_S * 1024); push(btok(8'h98, 1'b1)); push(btok(8'h03, 1'b0));
    push(K_DW * 1024); push(btok(8'hC3, 1'b0)); push(K_P * 1024);
`endif
    start_txn(1'b1, 8'd1, 7'h4C, 8'h03, 8'hC3);
    finish_txn("nack");
    nack_addr = 1'b0;

    // reset in the middle of the address byte
    mon_en = 1'b0;
    @(negedge clk_50);
    start_txn(1'b1, 8'd1, 7'h4C, 8'h01, 8'h77);
    n = 0;
    while (scl_ticks != 4'd3 && n < 20000) begin
      @(negedge clk_50);
      n++;
    end
    check("mid_ticks_reached", int'(scl_ticks), 3);
    rst_n = 1'b0;
    #1;
    check("midrst_scl", int'(SCL), 1);
    check("midrst_sda", int'(SDA), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ticks", int'(scl_ticks), 0);
    check("midrst_rxreg", int'(rxReg), 0);
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50);
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk_50);
    push_write(8'h01, 8'h9E);
    start_txn(1'b1, 8'd1, 7'h4C, 8'h01, 8'h9E);
    finish_txn("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-master I2C controller that issues register-addressed write and read transactions to a 7-bit slave: START, address, sub-address, data bytes, STOP.
- Sits between a host-side byte interface (txReg/rxReg with DE byte strobe) and the I2C pins.
- Runs from the 50 MHz system clock; SCL is derived by a programmable divider.

Parameters:
- QTR_DIV, 125, clk_50 cycles per quarter SCL period (125 gives 100 kHz from 50 MHz); minimum 2.

Ports:
- clk_50  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- WR  in  1  1 = write transaction, 0 = read transaction; sampled at START.
- length  in  8  data bytes per transaction; sampled at START; 0 is treated as 1.
- request  in  1  level; high starts a transaction, and keeps starting new ones back-to-back while held.
- address  in  7  slave address; sampled at START.
- sub_address  in  8  register address sent after the slave address; sampled at START.
- txReg  in  8  next write byte; latched into the shifter at each data byte start.
- rxReg  out  8  last received byte.
- DE  out  1  one-clk byte strobe. Write: txReg has just been consumed, so load the next byte. Read: rxReg is newly valid.
- SDA  inout  1  open-drain data: drives 0 or releases to Z; external pull-up.
- SCL  out  1  serial clock, push-pull; idles high.
- busy  out  1  high from START until STOP completes.
- scl_ticks  out  4  bit index within the current 9-bit frame (0..8; 8 = ACK slot); 0 when idle.

Behaviour:
- Reset values: SCL=1, SDA released, DE=0, busy=0, rxReg=0, scl_ticks=0, FSM=IDLE.
- Reset is honoured mid-transfer with no STOP generated.
- Timing: each SCL bit is 4 quarters: low, low, high, high.
  - Master changes SDA only at the start of quarter 1 (SCL low).
  - Master samples SDA at the end of quarter 2, the midpoint of SCL high.
- FSM states: IDLE, START, ADDR_W, SUB, RSTART, ADDR_R, WDATA, RDATA, STOP. Each byte state covers 8 data bits plus 1 ACK bit, MSB first.
- IDLE -> START when request=1.
  - On entry: busy=1; latch WR, length, address, sub_address; byte counter = length (0 -> 1).
- START: with SCL high, SDA falls; after one quarter SCL falls. Then -> ADDR_W.
- ADDR_W: sends {address,0}, then the ACK slot (SDA released, sampled). Then -> SUB.
- SUB: sends sub_address plus ACK slot. Then -> WDATA if WR=1, else -> RSTART.
- WDATA:
  - At bit 0 quarter 0: txReg -> shifter and DE pulses for 1 clk.
  - Sends 8 bits plus ACK slot, then decrements the byte counter.
  - Counter nonzero -> WDATA; counter zero -> STOP.
- RSTART: release SDA with SCL low, raise SCL, pull SDA low while SCL high, lower SCL. Then -> ADDR_R.
- ADDR_R: sends {address,1} plus ACK slot. Then -> RDATA.
- RDATA:
  - SDA released for 8 bits; sampled bits shift in MSB first.
  - After bit 7 is sampled: rxReg updates and DE pulses for 1 clk.
  - ACK slot: master drives 0 if more bytes remain; releases (NACK) on the last byte.
  - Decrement counter; zero -> STOP.
- STOP: SDA low with SCL low, SCL high, then one quarter later SDA released. After one further bus-free quarter: busy=0 -> IDLE.
  - request still high -> new START next clk.
  - request dropping mid-transaction does not abort; the current transaction completes.
- scl_ticks increments at each SCL falling edge within a frame and resets to 0 at each frame start.
- Input changes after START sampling have no effect until the next transaction; txReg is read only at DE time.

Optional Feature:
- Macro I2C_NACK_ABORT_EN.
  - Defined: a slave NACK (SDA high) in any master-transmit ACK slot (ADDR_W, SUB, ADDR_R, WDATA) goes directly to STOP. The transaction ends, busy drops, and no further DE pulses occur.
  - Undefined: ACK slots are sampled but ignored; the transaction always runs to completion.

Test Plan:
- Write, length=1, WR=1, address=0x4C, sub_address=0x01, txReg=0x12, slave ACKs all slots.
  -> Bits on SCL rises: 0x98, ACK, 0x01, ACK, 0x12, ACK, then STOP.
  -> Exactly one DE pulse; busy high from START to STOP.
- Held request, write stream: txReg reloaded from 0x78563412 LSB first on each DE, request dropped at the 4th DE.
  -> Four transactions carrying data 0x12, 0x34, 0x56, 0x78 in order, each framed by START/STOP; busy=0 afterwards.
- Read, length=2, WR=0, address=0x4C, sub_address=0x05, slave returns 0xA5 then 0x3C.
  -> Repeated START, then 0x99.
  -> rxReg=0xA5 with DE, master ACK; then rxReg=0x3C with DE, master NACK; then STOP.
- length=0 with WR=1 -> identical to length=1: one data byte, one DE.
- Slave NACKs the address byte.
  -> With I2C_NACK_ABORT_EN: STOP follows immediately, no DE, busy=0.
  -> Without it: the full transaction completes.
- rst_n asserted mid-byte -> SCL=1, SDA=Z, busy=0, scl_ticks=0 immediately. Next request starts a clean START.
